fpga_data_sink: RTL and testbench

AXI4-Stream byte sink with an Avalon-MM CSR slave. It is the receive-side counterpart of the FPGA data source. When armed by software, it accepts one packet (8-bit beats, terminated by tlast) into a 32-byte buffer and reports completion, length and overflow. The HPS then reads the captured bytes back through the register window.

---
 rtl/fpga_data_sink_if.sv | 25 ++
 rtl/fpga_data_sink.sv | 144 ++++++++++++++
 tb/tb_fpga_data_sink.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fpga_data_sink_if.sv
// Bus bundle for the data sink: Avalon-MM CSR window plus the AXI4-Stream byte input.
// The sink is the slave on both buses; the driving side uses the master modport.
interface fpga_data_sink_if;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [7:0]  axis4_s_tdata;
  logic        axis4_s_tvalid;
  logic        axis4_s_tlast;
  logic        axis4_s_tready;

  modport slave (
    input  avs_address, avs_chipselect, avs_write_n, avs_writedata,
    input  axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    output avs_readdata, axis4_s_tready
  );

  modport master (
    output avs_address, avs_chipselect, avs_write_n, avs_writedata,
    output axis4_s_tdata, axis4_s_tvalid, axis4_s_tlast,
    input  avs_readdata, axis4_s_tready
  );
endinterface

// File: rtl/fpga_data_sink.sv
// AXI4-Stream byte sink: captures one armed packet into a small buffer and exposes
// status, statistics and the captured bytes through a four-word CSR window.
module fpga_data_sink #(
  parameter int DEPTH_LOG2 = 5
) (
  input logic              clk,
  input logic              reset,
  fpga_data_sink_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DROP = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_inc;
  logic                  r_done;
  logic                  r_ovf;
  logic [DEPTH_LOG2-1:0] r_rdptr;
  logic [15:0]           r_beats;
  logic [7:0]            r_pkts;
  logic [7:0]            r_mem [DEPTH];

  logic w_wr;
  logic w_ctrl_wr;
  logic w_arm;
  logic w_abort;
  logic w_clr;
  logic w_rdptr_wr;
  logic w_beat;
  logic w_store;
  logic w_enter_recv;
  logic w_enter_done;

  assign w_wr         = bus.avs_chipselect & ~bus.avs_write_n;
  assign w_ctrl_wr    = w_wr && (bus.avs_address == 2'd0);
  assign w_arm        = w_ctrl_wr & bus.avs_writedata[0];
  assign w_abort      = w_ctrl_wr & bus.avs_writedata[1];
  assign w_clr        = w_ctrl_wr & bus.avs_writedata[31];
  assign w_rdptr_wr   = w_wr && (bus.avs_address == 2'd2);
  // tready comes straight from the state register so it has no combinational input path
  assign bus.axis4_s_tready = (r_state == RECV) || (r_state == DROP);
  assign w_beat       = bus.axis4_s_tvalid & bus.axis4_s_tready;
  assign w_store      = w_beat && (r_state == RECV);
  assign w_count_inc  = r_count + {{DEPTH_LOG2{1'b0}}, 1'b1};
  assign w_enter_recv = (w_next_state == RECV) && (r_state != RECV);
  assign w_enter_done = (w_next_state == DONE) && (r_state != DONE);

  // Next-state decode; ABORT overrides everything, ARM only acts from IDLE/DONE
  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_arm) w_next_state = RECV; else w_next_state = IDLE;
        RECV: begin
          if (w_beat && bus.axis4_s_tlast) begin
            w_next_state = DONE;
          end else if (w_beat && (w_count_inc == DEPTH[DEPTH_LOG2:0])) begin
            w_next_state = DROP;
          end else begin
            w_next_state = RECV;
          end
        end
        DROP: if (w_beat && bus.axis4_s_tlast) w_next_state = DONE; else w_next_state = DROP;
        DONE: if (w_arm) w_next_state = RECV; else w_next_state = DONE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // State, capture bookkeeping, read pointer and statistics counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wptr  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_rdptr <= '0;
      r_beats <= 16'd0;
      r_pkts  <= 8'd0;
    end else begin
      r_state <= w_next_state;
      if (w_enter_recv) begin
        r_wptr  <= '0;
        r_count <= '0;
        r_done  <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_store) begin
          r_wptr  <= r_wptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
          r_count <= w_count_inc;
        end
        if ((w_next_state == DROP) && (r_state == RECV)) r_ovf <= 1'b1;
        if (w_enter_done) r_done <= 1'b1;
      end
      if (w_rdptr_wr) r_rdptr <= bus.avs_writedata[DEPTH_LOG2-1:0];
      if (w_clr) begin
        r_beats <= 16'd0;
        r_pkts  <= 8'd0;
      end else begin
        if (w_beat) r_beats <= r_beats + 16'd1;
        if (w_enter_done) r_pkts <= r_pkts + 8'd1;
      end
    end
  end

  // Packet buffer; intentionally not reset
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wptr] <= bus.axis4_s_tdata;
  end

  // Zero-wait-state CSR read mux
  always_comb begin
    bus.avs_readdata = 32'd0;
    case (bus.avs_address)
      2'd0: bus.avs_readdata = 32'd0;
      2'd1: begin
        bus.avs_readdata[0]                  = (r_state == RECV) || (r_state == DROP);
        bus.avs_readdata[1]                  = r_done;
        bus.avs_readdata[2]                  = r_ovf;
        bus.avs_readdata[8 +: DEPTH_LOG2+1]  = r_count;
        bus.avs_readdata[17:16]              = r_state;
      end
      2'd2: begin
        bus.avs_readdata[7:0]              = r_mem[r_rdptr];
        bus.avs_readdata[8 +: DEPTH_LOG2]  = r_rdptr;
      end
      2'd3: bus.avs_readdata = {8'd0, r_pkts, r_beats};
      default: bus.avs_readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_fpga_data_sink.sv
// Directed bench for fpga_data_sink: stimulus pushes expected CSR/tready values into a
// scoreboard queue and a negedge monitor pops and compares them.
module tb_fpga_data_sink;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic mon_rd;
  logic mon_rdy;
  logic [31:0] q_exp[$];
  string       q_name[$];

  fpga_data_sink_if bus ();

  fpga_data_sink #(.DEPTH_LOG2(5)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", n, act, exp);
    end
  endtask

  // Monitor: compare whenever a read or tready observation is presented
  always @(negedge clk) begin
    if (mon_rd || mon_rdy) begin
      if (q_exp.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        string n;
        e = q_exp.pop_front();
        n = q_name.pop_front();
        if (mon_rd) check(n, bus.avs_readdata, e);
        else        check(n, {31'd0, bus.axis4_s_tready}, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d;
    bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b0;
    step();
    bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    bus.avs_address = a; bus.avs_chipselect = 1'b1; bus.avs_write_n = 1'b1;
    q_exp.push_back(e); q_name.push_back(n);
    mon_rd = 1'b1;
    step();
    mon_rd = 1'b0; bus.avs_chipselect = 1'b0;
  endtask

  task automatic chk_rdy(input logic e, input string n);
    q_exp.push_back({31'd0, e}); q_name.push_back(n);
    mon_rdy = 1'b1;
    step();
    mon_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int waited;
    waited = 0;
    while (bus.axis4_s_tready !== 1'b1 && waited < 16) begin
      step();
      waited++;
    end
    if (waited >= 16) check("tready_timeout", 32'd0, 32'd1);
    bus.axis4_s_tdata = d; bus.axis4_s_tlast = last; bus.axis4_s_tvalid = 1'b1;
    step();
    bus.axis4_s_tvalid = 1'b0; bus.axis4_s_tlast = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; mon_rd = 1'b0; mon_rdy = 1'b0;
    rst = 1'b1;
    bus.avs_address = 2'd0; bus.avs_chipselect = 1'b0; bus.avs_write_n = 1'b1;
    bus.avs_writedata = 32'd0; bus.axis4_s_tdata = 8'd0;
    bus.axis4_s_tvalid = 1'b0; bus.axis4_s_tlast = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    step();

    rd(2'd1, 32'h0000_0000, "reset_stat");
    rd(2'd3, 32'h0000_0000, "reset_dbg");
    rd(2'd0, 32'h0000_0000, "ctrl_reads_zero");
    chk_rdy(1'b0, "reset_tready");

    // 4-byte packet
    csr_wr(2'd0, 32'h0000_0001);
    chk_rdy(1'b1, "armed_tready");
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    chk_rdy(1'b0, "done_tready");
    rd(2'd1, 32'h0003_0402, "pkt4_stat");
    csr_wr(2'd2, 32'h0000_0002);
    rd(2'd2, 32'h0000_0233, "pkt4_rdptr2");
    rd(2'd3, 32'h0001_0004, "pkt4_dbg");

    // 40-byte overflowing packet
    csr_wr(2'd0, 32'h0000_0001);
    for (int i = 0; i < 40; i++) send(8'(i), (i == 39) ? 1'b1 : 1'b0);
    rd(2'd1, 32'h0003_2006, "ovf_stat");
    rd(2'd3, 32'h0002_002C, "ovf_dbg");
    csr_wr(2'd2, 32'h0000_001F);
    rd(2'd2, 32'h0000_1F1F, "ovf_rdptr31");

    // Idle armed, then abort; later beats must not be taken
    csr_wr(2'd0, 32'h0000_0001);
    rd(2'd1, 32'h0001_0001, "armed_stat");
    for (int i = 0; i < 10; i++) step();
    csr_wr(2'd0, 32'h0000_0002);
    rd(2'd1, 32'h0000_0000, "abort_stat");
    chk_rdy(1'b0, "abort_tready");
    bus.axis4_s_tdata = 8'h77; bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tlast = 1'b1;
    step(); step(); step();
    bus.axis4_s_tvalid = 1'b0; bus.axis4_s_tlast = 1'b0;
    rd(2'd3, 32'h0002_002C, "abort_no_beat_dbg");
    csr_wr(2'd2, 32'h0000_0003);
    rd(2'd2, 32'h0000_0303, "abort_mem_kept");

    // Back-to-back packets, re-armed the cycle after DONE
    csr_wr(2'd0, 32'h0000_0001);
    send(8'hA5, 1'b1);
    csr_wr(2'd0, 32'h0000_0001);
    send(8'h5A, 1'b0); send(8'hC3, 1'b1);
    rd(2'd1, 32'h0003_0202, "b2b_stat");
    rd(2'd3, 32'h0004_002F, "b2b_dbg");
    csr_wr(2'd2, 32'h0000_0000);
    rd(2'd2, 32'h0000_005A, "b2b_byte0");
    csr_wr(2'd2, 32'h0000_0001);
    rd(2'd2, 32'h0000_01C3, "b2b_byte1");

    // ABORT at the same edge as a beat still commits the beat
    csr_wr(2'd0, 32'h0000_0001);
    bus.axis4_s_tdata = 8'h99; bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tlast = 1'b0;
    csr_wr(2'd0, 32'h0000_0002);
    bus.axis4_s_tvalid = 1'b0;
    rd(2'd1, 32'h0000_0100, "abort_beat_stat");
    rd(2'd3, 32'h0004_0030, "abort_beat_dbg");
    csr_wr(2'd2, 32'h0000_0000);
    rd(2'd2, 32'h0000_0099, "abort_beat_mem");

    // CLR_CNT at the same edge as a beat
    csr_wr(2'd0, 32'h0000_0001);
    bus.axis4_s_tdata = 8'h10; bus.axis4_s_tvalid = 1'b1; bus.axis4_s_tlast = 1'b0;
    csr_wr(2'd0, 32'h8000_0000);
    bus.axis4_s_tvalid = 1'b0;
    rd(2'd3, 32'h0000_0000, "clr_dbg");
    send(8'h20, 1'b1);
    rd(2'd1, 32'h0003_0202, "clr_stat");
    rd(2'd3, 32'h0001_0001, "clr_dbg_after");
    rd(2'd2, 32'h0000_0010, "clr_mem");

    // Reset mid-packet
    csr_wr(2'd0, 32'h0000_0001);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    rd(2'd1, 32'h0001_0301, "pre_reset_stat");
    #2 rst = 1'b1;
    #1 check("async_reset_tready", {31'd0, bus.axis4_s_tready}, 32'd0);
    step(); step();
    rst = 1'b0;
    rd(2'd1, 32'h0000_0000, "post_reset_stat");
    rd(2'd3, 32'h0000_0000, "post_reset_dbg");
    rd(2'd2, 32'h0000_0001, "post_reset_rdptr_mem");
    csr_wr(2'd0, 32'h0000_0001);
    send(8'hEE, 1'b1);
    rd(2'd1, 32'h0003_0102, "rearm_stat");
    rd(2'd3, 32'h0001_0001, "rearm_dbg");

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
